// File: rtl/multicycle_controller.sv
// multicycle_controller: sequences each RV32I instruction through fetch,
// decode, execute, memory and writeback states. It drives every datapath
// select and enable, and bounds each memory request with a wait timeout.
`timescale 1ns/1ps
module multicycle_controller #(
  parameter int unsigned TIMEOUT         = 15,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  // A zero TIMEOUT disables the check; the counter still needs one bit.
  localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  // Illegal instructions either trap into HALT or retire as a NOP.
  localparam state_t S_ILLEGAL = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_bus_err;
  logic          r_illegal;
  logic          w_timeout;

  // Next-state and per-state datapath controls.
  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next     = r_state;
    w_timeout  = 1'b0;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    imm_src    = 3'b000;
    illegal_op = 1'b0;
    bus_err    = r_bus_err;
    state      = r_state;

    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here speculatively into alu_out.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b010;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BR:        w_next = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_ILLEGAL;
          OP_JAL:       w_next = S_JAL;
          OP_LUI:       w_next = S_LUI;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        // op[5] separates sw (S-immediate) from lw (I-immediate).
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = op[5] ? 3'b001 : 3'b000;
        w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        // funct3[0] inverts the sense of zero: beq takes on equal, bne on not-equal.
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero ^ funct3[0];
        w_next    = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from DECODE; ALUWB then writes old_pc+4.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        w_next    = S_ALUWB;
      end
      S_LUI: begin
        imm_src    = 3'b100;
        result_src = 2'b11;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_HALT: begin
        illegal_op = r_illegal;
      end
      default: w_next = S_HALT;
    endcase

    // A request stalled for TIMEOUT cycles aborts; mem_ready in that cycle still wins.
    w_timeout = (TIMEOUT != 0) && mem_req && !mem_ready && (r_cnt == CNT_LAST);
    if (w_timeout) w_next = S_HALT;

    // Outputs go quiet while reset is held, so no strobe escapes an abort.
    if (!rst_n) begin
      mem_req    = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      imm_src    = 3'b000;
      illegal_op = 1'b0;
      bus_err    = 1'b0;
      state      = 4'd0;
    end
  end

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Wait counter: counts stalled request cycles, cleared on any state change.
  // NOTE: only control state is reset here; the design holds no datapath storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_cnt <= '0;
    else if (w_next != r_state)   r_cnt <= '0;
    else if (mem_req && !mem_ready) r_cnt <= r_cnt + 1'b1;
  end

  // Sticky status flags recording why HALT was entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_err <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_timeout) r_bus_err <= 1'b1;
      if (r_state == S_DECODE && w_next == S_HALT) r_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed per-cycle vectors with
// hand-computed control words, checked by a queue-based scoreboard monitor.
`timescale 1ns/1ps
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;
  logic       illegal_op, bus_err;
  logic [3:0] state;

  multicycle_controller #(.TIMEOUT(15), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
    .illegal_op(illegal_op), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  // Control word: {state, mem_req, adr_src, mem_write, ir_write, pc_write,
  // reg_write, alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal_op, bus_err}
  typedef struct {
    logic [22:0] v;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         LU = 7'b0110111, BAD = 7'b1111111;

  function automatic logic [22:0] ex(
    input logic [3:0] st, input logic req, input logic adr, input logic mw,
    input logic irw, input logic pcw, input logic rw, input logic [1:0] a,
    input logic [1:0] b, input logic [1:0] aop, input logic [1:0] rs,
    input logic [2:0] imm, input logic ill, input logic be);
    return {st, req, adr, mw, irw, pcw, rw, a, b, aop, rs, imm, ill, be};
  endfunction

  // Hand-written control words for each state.
  function automatic logic [22:0] e_fetch(input logic r);
    return ex(4'd0, 1, 0, 0, r, r, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
  endfunction
  function automatic logic [22:0] e_decode();
    return ex(4'd1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b010, 0, 0);
  endfunction
  function automatic logic [22:0] e_memadr(input logic [2:0] imm);
    return ex(4'd2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, imm, 0, 0);
  endfunction
  function automatic logic [22:0] e_memread();
    return ex(4'd3, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [22:0] e_memwb();
    return ex(4'd4, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0);
  endfunction
  function automatic logic [22:0] e_memwrite();
    return ex(4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [22:0] e_execr();
    return ex(4'd6, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [22:0] e_execi();
    return ex(4'd7, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [22:0] e_aluwb();
    return ex(4'd8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [22:0] e_branch(input logic pcw);
    return ex(4'd9, 0, 0, 0, 0, pcw, 0, 2'b10, 2'b00, 2'b01, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [22:0] e_jal();
    return ex(4'd10, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [22:0] e_lui();
    return ex(4'd11, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b100, 0, 0);
  endfunction
  function automatic logic [22:0] e_halt(input logic ill, input logic be);
    return ex(4'd15, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, ill, be);
  endfunction

  // Drive one cycle of inputs and queue the control word expected in that cycle.
  task automatic cyc(input logic [6:0] o, input logic [2:0] f, input logic z,
                     input logic r, input logic [22:0] e, input string nm);
    op        = o;
    funct3    = f;
    zero      = z;
    mem_ready = r;
    sb_q.push_back('{v: e, name: nm});
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the live control word mid-cycle against the queue head.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t        e;
      logic [22:0] act;
      e   = sb_q.pop_front();
      act = {state, mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal_op, bus_err};
      n_vec++;
      if (act !== e.v) begin
        n_miss++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; op = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;

    // Reset state, including mem_ready high while held.
    cyc(LW, 3'b000, 0, 0, 23'd0, "reset_idle");
    cyc(LW, 3'b000, 0, 1, 23'd0, "reset_ready");

    // lw with zero-wait memory: states 0,1,2,3,4 then back to 0.
    rst_n = 1'b1;
    cyc(LW, 3'b000, 0, 1, e_fetch(1),      "lw_fetch");
    cyc(LW, 3'b000, 0, 1, e_decode(),      "lw_decode");
    cyc(LW, 3'b000, 0, 1, e_memadr(3'b000), "lw_memadr");
    cyc(LW, 3'b000, 0, 1, e_memread(),     "lw_memread");
    cyc(LW, 3'b000, 0, 1, e_memwb(),       "lw_memwb");

    // sw with mem_ready held low 3 cycles in MEMWRITE: 7 cycles total.
    cyc(SW, 3'b000, 0, 1, e_fetch(1),      "sw_fetch");
    cyc(SW, 3'b000, 0, 1, e_decode(),      "sw_decode");
    cyc(SW, 3'b000, 0, 1, e_memadr(3'b001), "sw_memadr");
    for (int i = 0; i < 3; i++) cyc(SW, 3'b000, 0, 0, e_memwrite(), "sw_memwrite_wait");
    cyc(SW, 3'b000, 0, 1, e_memwrite(),    "sw_memwrite_done");

    // Branches: beq taken, beq not taken, bne taken, bne not taken.
    cyc(BR, 3'b000, 1, 1, e_fetch(1), "beq1_fetch");
    cyc(BR, 3'b000, 1, 1, e_decode(), "beq1_decode");
    cyc(BR, 3'b000, 1, 1, e_branch(1), "beq_zero1");
    cyc(BR, 3'b000, 0, 1, e_fetch(1), "beq0_fetch");
    cyc(BR, 3'b000, 0, 1, e_decode(), "beq0_decode");
    cyc(BR, 3'b000, 0, 1, e_branch(0), "beq_zero0");
    cyc(BR, 3'b001, 0, 1, e_fetch(1), "bne0_fetch");
    cyc(BR, 3'b001, 0, 1, e_decode(), "bne0_decode");
    cyc(BR, 3'b001, 0, 1, e_branch(1), "bne_zero0");
    cyc(BR, 3'b001, 1, 1, e_fetch(1), "bne1_fetch");
    cyc(BR, 3'b001, 1, 1, e_decode(), "bne1_decode");
    cyc(BR, 3'b001, 1, 1, e_branch(0), "bne_zero1");

    // jal then lui.
    cyc(JL, 3'b000, 0, 1, e_fetch(1), "jal_fetch");
    cyc(JL, 3'b000, 0, 1, e_decode(), "jal_decode");
    cyc(JL, 3'b000, 0, 1, e_jal(),    "jal_jal");
    cyc(JL, 3'b000, 0, 1, e_aluwb(),  "jal_aluwb");
    cyc(LU, 3'b000, 0, 1, e_fetch(1), "lui_fetch");
    cyc(LU, 3'b000, 0, 1, e_decode(), "lui_decode");
    cyc(LU, 3'b000, 0, 1, e_lui(),    "lui_lui");

    // R-type and I-type ALU instructions.
    cyc(RT, 3'b000, 0, 1, e_fetch(1), "r_fetch");
    cyc(RT, 3'b000, 0, 1, e_decode(), "r_decode");
    cyc(RT, 3'b000, 0, 1, e_execr(),  "r_execr");
    cyc(RT, 3'b000, 0, 1, e_aluwb(),  "r_aluwb");
    cyc(IT, 3'b000, 0, 1, e_fetch(1), "i_fetch");
    cyc(IT, 3'b000, 0, 1, e_decode(), "i_decode");
    cyc(IT, 3'b000, 0, 1, e_execi(),  "i_execi");
    cyc(IT, 3'b000, 0, 1, e_aluwb(),  "i_aluwb");

    // Boundary: mem_ready arrives in the 15th (last allowed) request cycle.
    for (int i = 0; i < 14; i++) cyc(LU, 3'b000, 0, 0, e_fetch(0), "fetch_late_wait");
    cyc(LU, 3'b000, 0, 1, e_fetch(1), "fetch_late_ready");
    cyc(LU, 3'b000, 0, 1, e_decode(), "late_decode");
    cyc(LU, 3'b000, 0, 1, e_lui(),    "late_lui");

    // bne-family funct3 that is not 000/001 traps as illegal.
    cyc(BR, 3'b010, 0, 1, e_fetch(1), "badbr_fetch");
    cyc(BR, 3'b010, 0, 1, e_decode(), "badbr_decode");
    cyc(BR, 3'b010, 0, 1, e_halt(1, 0), "badbr_halt");
    rst_n = 1'b0;
    cyc(LW, 3'b000, 0, 1, 23'd0, "badbr_reset");
    rst_n = 1'b1;

    // Illegal opcode traps and HALT absorbs regardless of mem_ready.
    cyc(BAD, 3'b000, 0, 1, e_fetch(1), "ill_fetch");
    cyc(BAD, 3'b000, 0, 1, e_decode(), "ill_decode");
    cyc(BAD, 3'b000, 0, 1, e_halt(1, 0), "ill_halt");
    cyc(LW,  3'b000, 0, 0, e_halt(1, 0), "ill_halt_hold0");
    cyc(LW,  3'b000, 0, 1, e_halt(1, 0), "ill_halt_hold1");
    rst_n = 1'b0;
    cyc(LW, 3'b000, 0, 1, 23'd0, "ill_reset");
    rst_n = 1'b1;

    // Timeout: mem_ready stuck low in FETCH, request held exactly 15 cycles.
    for (int i = 0; i < 15; i++) cyc(LW, 3'b000, 0, 0, e_fetch(0), "to_fetch_wait");
    cyc(LW, 3'b000, 0, 0, e_halt(0, 1), "to_halt");
    cyc(LW, 3'b000, 0, 1, e_halt(0, 1), "to_halt_sticky1");
    cyc(LW, 3'b000, 0, 0, e_halt(0, 1), "to_halt_sticky2");
    rst_n = 1'b0;
    cyc(LW, 3'b000, 0, 0, 23'd0, "to_reset");
    rst_n = 1'b1;

    // Reset asserted mid-MEMWRITE aborts the store immediately.
    cyc(SW, 3'b000, 0, 1, e_fetch(1),       "abort_fetch");
    cyc(SW, 3'b000, 0, 1, e_decode(),       "abort_decode");
    cyc(SW, 3'b000, 0, 1, e_memadr(3'b001), "abort_memadr");
    cyc(SW, 3'b000, 0, 0, e_memwrite(),     "abort_memwrite");
    rst_n = 1'b0;
    cyc(SW, 3'b000, 0, 1, 23'd0, "abort_reset");
    cyc(SW, 3'b000, 0, 1, 23'd0, "abort_reset_hold");
    rst_n = 1'b1;
    cyc(SW, 3'b000, 0, 0, e_fetch(0), "abort_refetch");

    @(negedge clk);
    #1;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequential control unit for the multicycle RV32I core, replacing the single-cycle combinational opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath select and enable, and waits on a ready/valid-style memory handshake with a bounded timeout. It also covers bne, U-type immediates and illegal-opcode trapping, which the single-cycle decoder lacks.

## Interface
Parameters:
- TIMEOUT, 15, max cycles a memory request may wait for mem_ready before bus_err; 0 disables the timeout.
- TRAP_ON_ILLEGAL, 1, 1: illegal op/funct3 enters HALT; 0: treated as NOP (DECODE -> FETCH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- op  in  7  instr[6:0] from instruction register.
- funct3  in  3  instr[14:12]; branch: 000 beq, 001 bne, others illegal.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current request this cycle.
- mem_req  out  1  memory request active.
- adr_src  out  1  0: PC, 1: alu_out register.
- mem_write  out  1  store strobe, qualified by mem_req.
- ir_write  out  1  load instruction register and old_pc.
- pc_write  out  1  load PC from result.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  00 PC, 01 old_pc, 10 rs1.
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
- alu_op  out  2  00 add, 01 sub (compare), 10 funct-decoded.
- result_src  out  2  00 alu_out reg, 01 read data, 10 ALU result, 11 imm.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- illegal_op  out  1  high while in HALT due to illegal instruction.
- bus_err  out  1  sticky; memory timeout occurred.
- state  out  4  current state code for debug.

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11, HALT=15.
- Every output not listed for a state is 0.
- FETCH: mem_req=1, alu_src_b=10, result_src=10. ir_write and pc_write are 1 only when mem_ready=1. On mem_ready go to DECODE, otherwise stay.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=010 (branch target into alu_out). Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 with funct3 000/001 -> BRANCH.
  - 1101111 -> JAL.
  - 0110111 -> LUI.
  - Anything else -> HALT or FETCH, per TRAP_ON_ILLEGAL.
- MEMADR: alu_src_a=10, alu_src_b=01, imm_src=000 for lw and 001 for sw. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. On mem_ready -> MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: mem_req=1, adr_src=1, mem_write=1. On mem_ready -> FETCH.
- EXECR: alu_src_a=10, alu_op=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: reg_write=1, result_src=00 -> FETCH.
- BRANCH: alu_src_a=10, alu_op=01, result_src=00. pc_write = zero XOR funct3[0] (combinational). -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1 (target from DECODE) -> ALUWB, which writes old_pc+4.
- LUI: imm_src=100, result_src=11, reg_write=1 -> FETCH.
- HALT: absorbing until reset.
  - illegal_op=1 if entered from DECODE.
  - bus_err=1 if entered via timeout.

## Timing
- Reset (rst_n low, asynchronous): state=FETCH, wait counter=0, bus_err=0. All outputs are forced 0 while rst_n is low. The first mem_req appears in the first cycle after deassertion.
- Zero-wait memory (mem_ready high in the first request cycle) gives these cycle counts: lw 5, sw 4, R 4, I 4, branch 3, jal 4, lui 3.
- Each extra cycle of mem_ready low adds exactly 1 cycle.
- Wait counter:
  - Width is clog2(TIMEOUT+1).
  - It increments each cycle with mem_req=1 and mem_ready=0, and clears on any state change.
  - If counter==TIMEOUT-1 and mem_ready=0, the next edge enters HALT with bus_err=1. A request is therefore held for exactly TIMEOUT cycles.
  - mem_ready=1 in that same cycle wins: normal completion, no error.
- mem_ready is ignored when mem_req=0.
- Reset mid-operation aborts immediately: no further write or strobe is issued, even in MEMWRITE.

## Test plan
- Reset, then fetch lw (op=0000011) with mem_ready always 1 -> states 0,1,2,3,4,0. reg_write=1 and result_src=01 only in cycle 5. pc_write=1 only in cycle 1.
- sw with mem_ready delayed 3 cycles in MEMWRITE -> mem_write=1, adr_src=1 held 4 cycles, then FETCH. Total 7 cycles.
- BRANCH with funct3=000/zero=1, 000/0, 001/0, 001/1 -> pc_write = 1, 0, 1, 0 respectively. Each instruction takes 3 cycles.
- jal then lui -> JAL pc_write=1 then ALUWB reg_write=1 with result_src=00. LUI reg_write=1 with result_src=11, imm_src=100.
- TIMEOUT=15 with mem_ready stuck 0 in FETCH -> mem_req held 15 cycles. HALT with bus_err=1 on the 16th cycle, persisting until rst_n low.
- op=1111111 with TRAP_ON_ILLEGAL=1 -> HALT, illegal_op=1. Assert rst_n low mid-MEMWRITE -> all outputs 0 immediately, state=0.
